demux1ne6_seq: RTL and testbench

- Registered 1-to-6 demultiplexer; the distribution-side counterpart of the team's 6:1 selection mux.
- Accepts a single data stream over a valid/ready handshake and steers each word into one of six slot registers.
- The target slot comes from an explicit 3-bit select (manual mode) or an internal round-robin pointer (auto mode).
- Tracks slot occupancy and flags full, illegal-select and overwrite conditions for the downstream datapath.

---
 rtl/demux_pkg.sv | 19 +
 rtl/demux_slot_reg.sv | 16 +
 rtl/demux1ne6_seq.sv | 89 ++++++++
 tb/tb_demux1ne6_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants for the registered 1:6 demultiplexer.
// Slot count, select width, FSM encodings and mode values.
package demux_pkg;
  localparam int NUM_SLOTS = 6;
  localparam int SEL_W = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO = 1'b1;

  function automatic logic [SEL_W-1:0] ptr_next(
    input logic [SEL_W-1:0] p
  );
    return (p == SEL_W'(NUM_SLOTS - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/demux_slot_reg.sv
// One slot register of the 1:6 demultiplexer.
// Holds its word until the next write or reset.
module demux_slot_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (we) q <= d;
  end
endmodule

// File: rtl/demux1ne6_seq.sv
// Registered 1:6 demux with manual/auto slot selection,
// occupancy tracking and full/err/ovr flags.
module demux1ne6_seq
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [SEL_W-1:0] S,
  input  logic             clear,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic             full,
  output logic             err,
  output logic             ovr
);
  logic [SEL_W-1:0]     ptr_q;
  logic [1:0]           state_q, state_d;
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [NUM_SLOTS-1:0] wr_en;
  logic [WIDTH-1:0]     slot_q [NUM_SLOTS];
  logic [SEL_W-1:0]     tgt;
  logic                 auto_m, xfer, legal;

  assign auto_m = (mode == MODE_AUTO);
  assign full = (state_q == ST_FULL);
  assign in_ready = rst_n && !clear && !(auto_m && full);
  assign xfer = in_valid && in_ready;
  assign tgt = auto_m ? ptr_q : S;
  assign legal = auto_m || (S < SEL_W'(NUM_SLOTS));

  // One-hot write strobe; illegal selects never reach a slot
  assign wr_en = (xfer && legal)
               ? (NUM_SLOTS'(1) << tgt) : '0;
  assign valid_d = valid_q | wr_en;

  always_comb begin
    state_d = ST_IDLE;
    if (clear) state_d = ST_IDLE;
    else if (&valid_d) state_d = ST_FULL;
    else if (|valid_d) state_d = ST_FILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      state_q <= ST_IDLE;
      valid_q <= '0;
      err     <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= clear ? '0 : valid_d;
      err <= xfer && !auto_m && !legal;
      ovr <= xfer && (mode == MODE_MANUAL)
          && |(valid_q & wr_en);
      if (clear) ptr_q <= '0;
      else if (xfer && auto_m) ptr_q <= ptr_next(ptr_q);
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    demux_slot_reg #(.WIDTH(WIDTH)) u_reg (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (wr_en[k]),
      .d    (in_data),
      .q    (slot_q[k])
    );
  end

  assign slot_valid = valid_q;
  assign out0 = slot_q[0];
  assign out1 = slot_q[1];
  assign out2 = slot_q[2];
  assign out3 = slot_q[3];
  assign out4 = slot_q[4];
  assign out5 = slot_q[5];
endmodule

// File: tb/tb_demux1ne6_seq.sv
// Self-checking bench for demux1ne6_seq against a
// slot/occupancy reference model.
module tb_demux1ne6_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_ready, mode, clear;
  logic [2:0] S;
  logic [7:0] out0, out1, out2, out3, out4, out5;
  logic [5:0] slot_valid;
  logic       full, err, ovr;
  logic [7:0] outs [6];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_slot [6];
  logic [5:0] m_valid;
  int         m_ptr;
  logic       m_err, m_ovr, exp_rdy, obs_rdy;

  always #5 clk = ~clk;

  demux1ne6_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .S(S), .clear(clear),
    .out0(out0), .out1(out1), .out2(out2),
    .out3(out3), .out4(out4), .out5(out5),
    .slot_valid(slot_valid), .full(full),
    .err(err), .ovr(ovr)
  );

  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;
  assign outs[4] = out4;
  assign outs[5] = out5;

  task automatic model_reset();
    for (int k = 0; k < 6; k++) m_slot[k] = 8'h00;
    m_valid = '0;
    m_ptr = 0;
    m_err = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Drive one cycle, record pre-edge ready, advance the model
  task automatic step(input logic v, input logic m,
                      input logic [2:0] s,
                      input logic [7:0] d,
                      input logic c);
    in_valid = v; mode = m; S = s; in_data = d; clear = c;
    #1;
    exp_rdy = !c && !(m && (m_valid == 6'h3f));
    obs_rdy = in_ready;
    @(posedge clk);
    m_err = 1'b0;
    m_ovr = 1'b0;
    if (c) begin
      m_valid = '0;
      m_ptr = 0;
    end else if (v && exp_rdy) begin
      if (m) begin
        m_slot[m_ptr] = d;
        m_valid[m_ptr] = 1'b1;
        m_ptr = (m_ptr + 1) % 6;
      end else if (s > 3'd5) begin
        m_err = 1'b1;
      end else begin
        m_ovr = m_valid[s];
        m_slot[s] = d;
        m_valid[s] = 1'b1;
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; mode = 0; S = 0; in_data = 0; clear = 0;
    model_reset();
    #12;
    n_cmp++;
    if ({out0, out1, out2, out3, out4, out5} !== 48'h0 ||
        slot_valid !== 6'h0 || {full, err, ovr} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_state outs=%h sv=%b f/e/o=%b want 0",
               {out0, out1, out2, out3, out4, out5}, slot_valid,
               {full, err, ovr});
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready got %b want 0", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_auto_fill();
    for (int k = 0; k < 6; k++) begin
      step(1, 1, 0, 8'(8'h11 * (k + 1)), 0);
      n_cmp++;
      if (obs_rdy !== 1'b1) begin
        n_bad++;
        $display("FAIL auto_ready[%0d] got %b want 1", k, obs_rdy);
      end
    end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (outs[k] !== 8'(8'h11 * (k + 1))) begin
        n_bad++;
        $display("FAIL auto_out%0d got %h want %h", k, outs[k],
                 8'(8'h11 * (k + 1)));
      end
    end
    n_cmp++;
    if (slot_valid !== 6'h3f || full !== 1'b1) begin
      n_bad++;
      $display("FAIL auto_full sv=%b full=%b want 111111/1",
               slot_valid, full);
    end
    step(1, 1, 0, 8'h77, 0);
    n_cmp++;
    if (obs_rdy !== 1'b0 || out0 !== 8'h11) begin
      n_bad++;
      $display("FAIL auto_blocked rdy=%b out0=%h want 0/11",
               obs_rdy, out0);
    end
  endtask

  task automatic test_illegal();
    for (int i = 6; i < 8; i++) begin
      step(1, 0, 3'(i), 8'hAA, 0);
      n_cmp++;
      if (obs_rdy !== 1'b1 || err !== 1'b1) begin
        n_bad++;
        $display("FAIL illegal_err S=%0d rdy=%b err=%b want 1/1",
                 i, obs_rdy, err);
      end
      n_cmp++;
      if (slot_valid !== 6'h3f || out3 !== 8'h44 || ovr !== 1'b0) begin
        n_bad++;
        $display("FAIL illegal_nochg sv=%b out3=%h ovr=%b",
                 slot_valid, out3, ovr);
      end
      step(0, 0, 0, 8'h00, 0);
      n_cmp++;
      if (err !== 1'b0) begin
        n_bad++;
        $display("FAIL illegal_pulse err=%b want 0", err);
      end
    end
  endtask

  task automatic test_overwrite();
    step(0, 0, 0, 8'h00, 1);
    step(1, 0, 2, 8'h5A, 0);
    n_cmp++;
    if (out2 !== 8'h5A || ovr !== 1'b0 || slot_valid !== 6'b000100) begin
      n_bad++;
      $display("FAIL ovr_first out2=%h ovr=%b sv=%b want 5a/0/000100",
               out2, ovr, slot_valid);
    end
    step(1, 0, 2, 8'hC3, 0);
    n_cmp++;
    if (out2 !== 8'hC3 || ovr !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_second out2=%h ovr=%b want c3/1", out2, ovr);
    end
    step(0, 0, 0, 8'h00, 0);
    n_cmp++;
    if (ovr !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_pulse ovr=%b want 0", ovr);
    end
  endtask

  task automatic test_mode_switch();
    step(0, 0, 0, 8'h00, 1);
    step(1, 1, 0, 8'h01, 0);
    step(1, 1, 0, 8'h02, 0);
    step(1, 0, 5, 8'h09, 0);
    step(1, 1, 0, 8'h03, 0);
    n_cmp++;
    if (out2 !== 8'h03 || out5 !== 8'h09 || slot_valid !== 6'b100111) begin
      n_bad++;
      $display("FAIL mode_switch out2=%h out5=%h sv=%b want 03/09/100111",
               out2, out5, slot_valid);
    end
    step(1, 1, 0, 8'h04, 0);
    n_cmp++;
    if (out3 !== 8'h04) begin
      n_bad++;
      $display("FAIL mode_ptr out3=%h want 04", out3);
    end
  endtask

  task automatic test_clear();
    step(1, 1, 0, 8'hBB, 1);
    n_cmp++;
    if (obs_rdy !== 1'b0 || slot_valid !== 6'h0 || full !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_state rdy=%b sv=%b full=%b want 0/0/0",
               obs_rdy, slot_valid, full);
    end
    n_cmp++;
    if (out5 !== 8'h09 || out4 === 8'hBB) begin
      n_bad++;
      $display("FAIL clear_keep out5=%h out4=%h want 09/not bb",
               out5, out4);
    end
    step(1, 1, 0, 8'hEE, 0);
    n_cmp++;
    if (out0 !== 8'hEE || slot_valid !== 6'b000001) begin
      n_bad++;
      $display("FAIL clear_ptr out0=%h sv=%b want ee/000001",
               out0, slot_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom),
           3'($urandom), 8'($urandom),
           1'($urandom_range(0, 23) == 0));
      n_cmp++;
      if (obs_rdy !== exp_rdy) begin
        n_bad++;
        $display("FAIL rnd_ready[%0d] got %b want %b", n, obs_rdy,
                 exp_rdy);
      end
      n_cmp++;
      if (slot_valid !== m_valid || full !== (m_valid == 6'h3f) ||
          err !== m_err || ovr !== m_ovr) begin
        n_bad++;
        $display("FAIL rnd_flags[%0d] sv=%b f=%b e=%b o=%b want %b/%b/%b/%b",
                 n, slot_valid, full, err, ovr, m_valid,
                 (m_valid == 6'h3f), m_err, m_ovr);
      end
      for (int k = 0; k < 6; k++) begin
        n_cmp++;
        if (outs[k] !== m_slot[k]) begin
          n_bad++;
          $display("FAIL rnd_out%0d[%0d] got %h want %h", k, n,
                   outs[k], m_slot[k]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 8'h00, 1);
    step(1, 1, 0, 8'h21, 0);
    step(1, 1, 0, 8'h22, 0);
    mode = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out0, out1, out2, out3, out4, out5} !== 48'h0 ||
        slot_valid !== 6'h0 || full !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset outs=%h sv=%b full=%b rdy=%b want 0",
               {out0, out1, out2, out3, out4, out5}, slot_valid,
               full, in_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 1, 0, 8'h31, 0);
    n_cmp++;
    if (out0 !== 8'h31 || slot_valid !== 6'b000001) begin
      n_bad++;
      $display("FAIL async_ptr out0=%h sv=%b want 31/000001",
               out0, slot_valid);
    end
  endtask

  initial begin
    test_reset();
    test_auto_fill();
    test_illegal();
    test_overwrite();
    test_mode_switch();
    test_clear();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
